// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants, field bounds,
// FSM state type and the buffered fetch entry layout.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned ENTRY_W = 2 * XLEN;

    localparam logic [OPC_MSB-OPC_LSB:0] OP_J   = 6'b000010;
    localparam logic [OPC_MSB-OPC_LSB:0] OP_JAL = 6'b000011;

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // J target keeps the region bits of the sequential successor.
    function automatic logic [XLEN-1:0] j_target(input logic [XLEN-1:0] pc_plus4,
                                                 input logic [XLEN-1:0] inst);
        return {pc_plus4[31:28], inst[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst} fetch entries; flush has priority over push/pop,
// and the head reads as zero while empty.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] slot_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign do_pop  = pop & ~empty;
    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : slot_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, BOOT/RUN sequencing, local J redirect
// and a two-entry decode buffer with external redirect/flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter bit              J_PREDECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_next_seq;
    logic            is_j;
    logic            pop;
    logic            fetch;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign imem_pc  = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign is_j     = J_PREDECODE && (imem_inst[OPC_MSB:OPC_LSB] == OP_J);
    // JAL falls through here: it needs the link register, so downstream redirects it.
    assign pc_next_seq = is_j ? j_target(pc_plus4, imem_inst) : pc_plus4;

    assign pop   = ~buf_empty & dec_ready;
    assign fetch = (state_q == RUN) & ~redirect_valid & (~buf_full | pop);

    assign push_entry.pc   = pc_q;
    assign push_entry.inst = imem_inst;

    fetch_buffer u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign dec_valid = ~buf_empty;
    assign dec_inst  = head_entry.inst;
    assign dec_pc    = head_entry.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            state_q <= RUN;
            pc_q    <= redirect_pc & ~32'd3;
        end else if (state_q == BOOT) begin
            state_q <= RUN;
        end else if (fetch) begin
            pc_q    <= pc_next_seq;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed ROM model and one task per scenario,
// each comparing decode/fetch outputs against hand-computed values.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    int vectors;
    int miscompares;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .J_PREDECODE (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unlisted addresses return an addi-class word (opcode 001000), never a jump.
    function automatic logic [31:0] rom(input logic [31:0] pc);
        case (pc)
            32'h0000_0000: rom = 32'h3409_0005;
            32'h0000_0004: rom = 32'h340a_0005;
            32'h0000_0008: rom = 32'h340b_0008;
            32'h0000_002c: rom = 32'h25ad_0008;
            32'h0000_0030: rom = 32'h0800_0005;
            32'h0000_0034: rom = 32'h2108_0001;
            32'h0000_0100: rom = 32'h0c00_0010;
            32'h0000_0200: rom = 32'h0000_0000;
            32'h7000_0000: rom = 32'h0800_0005;
            default:       rom = {6'b001000, pc[25:0]};
        endcase
    endfunction

    assign imem_inst = rom(imem_pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = ready;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;
        #3;
        vectors++;
        if (dec_valid !== 1'b0 || dec_inst !== 32'h0 || dec_pc !== 32'h0 || imem_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: valid=%b inst=%h pc=%h imem_pc=%h, want 0/0/0/0",
                     dec_valid, dec_inst, dec_pc, imem_pc);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (dec_valid !== 1'b0 || imem_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL boot_no_fetch: valid=%b imem_pc=%h, want 0/00000000",
                     dec_valid, imem_pc);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc   [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_inst [3] = '{32'h3409_0005, 32'h340a_0005, 32'h340b_0008};
        do_reset(1'b1);
        step();
        vectors++;
        if (dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_first_edge: valid=%b, want 0", dec_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i] || dec_inst !== exp_inst[i]) begin
                miscompares++;
                $display("FAIL seq_%0d: valid=%b pc=%h inst=%h, want 1/%h/%h",
                         i, dec_valid, dec_pc, dec_inst, exp_pc[i], exp_inst[i]);
            end
        end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc [3] = '{32'h2c, 32'h30, 32'h14};
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2c;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (imem_pc !== 32'h2c || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_redirect: imem_pc=%h valid=%b, want 0000002c/0", imem_pc, dec_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL jump_seq_%0d: valid=%b pc=%h, want 1/%h",
                         i, dec_valid, dec_pc, exp_pc[i]);
            end
        end
        vectors++;
        if (imem_pc !== 32'h18) begin
            miscompares++;
            $display("FAIL jump_after: imem_pc=%h, want 00000018", imem_pc);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_jal_nop_upper();
        do_reset(1'b1);
        step();
        redirect_to(32'h100);
        step();
        vectors++;
        if (dec_pc !== 32'h100 || dec_inst !== 32'h0c00_0010 || imem_pc !== 32'h104) begin
            miscompares++;
            $display("FAIL jal_seq: pc=%h inst=%h imem_pc=%h, want 00000100/0c000010/00000104",
                     dec_pc, dec_inst, imem_pc);
        end
        redirect_to(32'h200);
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_inst !== 32'h0 ||
            imem_pc !== 32'h204) begin
            miscompares++;
            $display("FAIL nop_push: valid=%b pc=%h inst=%h imem_pc=%h, want 1/200/0/204",
                     dec_valid, dec_pc, dec_inst, imem_pc);
        end
        redirect_to(32'h7000_0000);
        step();
        vectors++;
        if (imem_pc !== 32'h7000_0014 || dec_inst !== 32'h0800_0005) begin
            miscompares++;
            $display("FAIL j_region: imem_pc=%h inst=%h, want 70000014/08000005",
                     imem_pc, dec_inst);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hc};
        do_reset(1'b0);
        step();
        step();
        step();
        vectors++;
        if (dec_pc !== 32'h0 || imem_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL stall_fill: pc=%h imem_pc=%h, want 0/8", dec_pc, imem_pc);
        end
        step();
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_inst !== 32'h3409_0005 ||
            imem_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL stall_hold: valid=%b pc=%h inst=%h imem_pc=%h, want 1/0/34090005/8",
                     dec_valid, dec_pc, dec_inst, imem_pc);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            vectors++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL drain_%0d: valid=%b pc=%h, want 1/%h",
                         i, dec_valid, dec_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset(1'b0);
        step();
        step();
        step();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h31;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (dec_valid !== 1'b0 || imem_pc !== 32'h30) begin
            miscompares++;
            $display("FAIL flush: valid=%b imem_pc=%h, want 0/00000030", dec_valid, imem_pc);
        end
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h30) begin
            miscompares++;
            $display("FAIL flush_refetch: valid=%b pc=%h, want 1/00000030", dec_valid, dec_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        step();
        redirect_to(32'hffff_fffc);
        step();
        vectors++;
        if (imem_pc !== 32'h0 || dec_pc !== 32'hffff_fffc) begin
            miscompares++;
            $display("FAIL wrap: imem_pc=%h pc=%h, want 00000000/fffffffc", imem_pc, dec_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        step();
        step();
        step();
        vectors++;
        if (dec_valid !== 1'b1 || imem_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL pre_async: valid=%b imem_pc=%h, want 1/8", dec_valid, imem_pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dec_valid !== 1'b0 || dec_inst !== 32'h0 || dec_pc !== 32'h0 || imem_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b inst=%h pc=%h imem_pc=%h, want 0/0/0/0",
                     dec_valid, dec_inst, dec_pc, imem_pc);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sequential();
        test_jump();
        test_jal_nop_upper();
        test_stall();
        test_redirect_flush();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
